// File: rtl/led_pkg.sv
// Shared encodings for LED pattern blocks: the mode select and the scanner/breathe direction.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_BIN     = 2'd0,
        MODE_GRAY    = 2'd1,
        MODE_SCAN    = 2'd2,
        MODE_BREATHE = 2'd3
    } led_mode_e;

    typedef enum logic {
        DirUp   = 1'b0,
        DirDown = 1'b1
    } led_dir_e;

endpackage

// File: rtl/tick_div.sv
// Prescaler: counts 0..DIV_CNT-1 while enabled and flags the terminal count as a one-cycle tick.
module tick_div #(
    parameter int unsigned DIV_CNT = 4194304
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    input  logic CLR,
    output logic TICK
);

    localparam int unsigned CntW = (DIV_CNT > 1) ? $clog2(DIV_CNT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DIV_CNT - 1);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;
    logic            at_last;

    assign at_last = (cnt_q == CntLast);

    always_comb begin
        cnt_d = cnt_q;
        if (CLR) begin
            cnt_d = '0;
        end else if (EN) begin
            cnt_d = at_last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A clear wins over a coincident terminal count; reset must also hide the tick when DIV_CNT=1.
    assign TICK = at_last & EN & ~CLR & ~RST;

endmodule

// File: rtl/led_pattern.sv
// LED pattern generator: binary, Gray, bouncing scanner and PWM breathe modes stepped by a
// prescaled tick, with a registered output one edge behind the pattern state.
module led_pattern
    import led_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DIV_CNT  = 4194304,
    parameter int unsigned PWM_BITS = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       MODE,
    input  logic             HOLD,
    output logic [WIDTH-1:0] OUT,
    output logic             TICK
);

    localparam int unsigned PosW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [PosW-1:0]     PosLast = PosW'(WIDTH - 1);
    localparam logic [PWM_BITS-1:0] DutyMax = '1;

    led_mode_e           mode_q;
    led_mode_e           mode_d;
    logic [WIDTH-1:0]    cnt_q;
    logic [WIDTH-1:0]    cnt_d;
    logic [PosW-1:0]     pos_q;
    logic [PosW-1:0]     pos_d;
    led_dir_e            dir_q;
    led_dir_e            dir_d;
    logic [PWM_BITS-1:0] duty_q;
    logic [PWM_BITS-1:0] duty_d;
    logic [PWM_BITS-1:0] pwm_q;
    logic [PWM_BITS-1:0] pwm_d;
    logic [WIDTH-1:0]    out_q;
    logic [WIDTH-1:0]    out_d;
    logic                mode_change;
    logic                step;

    assign mode_change = (MODE != mode_q);

    tick_div #(
        .DIV_CNT(DIV_CNT)
    ) u_tick_div (
        .CLK (CLK),
        .RST (RST),
        .EN  (~HOLD),
        .CLR (mode_change),
        .TICK(step)
    );

    assign TICK = step;
    assign OUT  = out_q;

    // Step state; a mode change reinitialises everything and overrides a coincident step.
    always_comb begin
        mode_d = mode_q;
        cnt_d  = cnt_q;
        pos_d  = pos_q;
        dir_d  = dir_q;
        duty_d = duty_q;
        if (mode_change) begin
            mode_d = led_mode_e'(MODE);
            cnt_d  = '0;
            pos_d  = '0;
            dir_d  = DirUp;
            duty_d = '0;
        end else if (step) begin
            unique case (mode_q)
                MODE_BIN, MODE_GRAY: begin
                    cnt_d = cnt_q + 1'b1;
                end
                MODE_SCAN: begin
                    if (WIDTH == 1) begin
                        pos_d = '0;
                    end else if (dir_q == DirUp) begin
                        if (pos_q == PosLast) begin
                            dir_d = DirDown;
                            pos_d = pos_q - 1'b1;
                        end else begin
                            pos_d = pos_q + 1'b1;
                        end
                    end else begin
                        if (pos_q == '0) begin
                            dir_d = DirUp;
                            pos_d = pos_q + 1'b1;
                        end else begin
                            pos_d = pos_q - 1'b1;
                        end
                    end
                end
                MODE_BREATHE: begin
                    if (dir_q == DirUp) begin
                        if (duty_q == DutyMax) begin
                            dir_d  = DirDown;
                            duty_d = duty_q - 1'b1;
                        end else begin
                            duty_d = duty_q + 1'b1;
                        end
                    end else begin
                        if (duty_q == '0) begin
                            dir_d  = DirUp;
                            duty_d = duty_q + 1'b1;
                        end else begin
                            duty_d = duty_q - 1'b1;
                        end
                    end
                end
                default: begin
                    cnt_d = cnt_q;
                end
            endcase
        end
    end

    // The PWM counter free-runs regardless of HOLD or mode changes.
    always_comb begin
        pwm_d = pwm_q + 1'b1;
    end

    always_comb begin
        out_d = '0;
        unique case (mode_q)
            MODE_BIN:     out_d = cnt_q;
            MODE_GRAY:    out_d = cnt_q ^ (cnt_q >> 1);
            MODE_SCAN:    out_d[pos_q] = 1'b1;
            MODE_BREATHE: out_d = {WIDTH{pwm_q < duty_q}};
            default:      out_d = '0;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mode_q <= MODE_BIN;
            cnt_q  <= '0;
            pos_q  <= '0;
            dir_q  <= DirUp;
            duty_q <= '0;
            pwm_q  <= '0;
            out_q  <= '0;
        end else begin
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            pos_q  <= pos_d;
            dir_q  <= dir_d;
            duty_q <= duty_d;
            pwm_q  <= pwm_d;
            out_q  <= out_d;
        end
    end

endmodule

// File: tb/tb_led_pattern.sv
// Randomized bench for led_pattern: a reference model tracks steps since the last mode change
// and derives each pattern arithmetically from that count.
module tb_led_pattern;

    localparam int W    = 4;
    localparam int DIV  = 3;
    localparam int PB   = 3;
    localparam int CMOD = 1 << W;
    localparam int DMAX = (1 << PB) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         hold;
    logic [1:0]   mode;
    logic [W-1:0] out;
    logic         tick;

    led_pattern #(
        .WIDTH   (W),
        .DIV_CNT (DIV),
        .PWM_BITS(PB)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .MODE(mode),
        .HOLD(hold),
        .OUT (out),
        .TICK(tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: prescaler phase, steps taken since the last mode change, active mode, edges since reset.
    int           m_phase;
    int           m_steps;
    int           m_mode;
    int           m_cyc;
    logic [W-1:0] m_out;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pattern(input int md, input int steps, input int cyc);
        int c;
        int p;
        int d;
        logic [W-1:0] r;
        case (md)
            0: r = W'(steps % CMOD);
            1: begin
                c = steps % CMOD;
                r = W'(c ^ (c >> 1));
            end
            2: begin
                if (W == 1) begin
                    p = 0;
                end else begin
                    p = steps % (2 * (W - 1));
                    if (p > W - 1) p = 2 * (W - 1) - p;
                end
                r = W'(1 << p);
            end
            default: begin
                d = steps % (2 * DMAX);
                if (d > DMAX) d = 2 * DMAX - d;
                r = ((cyc % (1 << PB)) < d) ? '1 : '0;
            end
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_steps = 0;
        m_mode  = 0;
        m_cyc   = 0;
        m_out   = '0;
    endtask

    // Entered at a falling edge; leaves at the next falling edge.
    task automatic cycle(input logic [1:0] md, input logic hd);
        logic exp_tick;
        mode = md;
        hold = hd;
        #1;
        exp_tick = (hd == 1'b0) && (int'(md) == m_mode) && (m_phase == DIV - 1);
        check_eq("tick", 32'(tick), 32'(exp_tick));
        check_eq("out", 32'(out), 32'(m_out));
        @(posedge clk);
        m_out = pattern(m_mode, m_steps, m_cyc);
        if (int'(md) != m_mode) begin
            m_mode  = int'(md);
            m_steps = 0;
            m_phase = 0;
        end else if (!hd) begin
            if (m_phase == DIV - 1) begin
                m_phase = 0;
                m_steps++;
            end else begin
                m_phase++;
            end
        end
        m_cyc++;
        @(negedge clk);
    endtask

    // Asserts reset between edges and checks outputs clear before any clock edge.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        check_eq("rst_out_async", 32'(out), 32'(0));
        check_eq("rst_tick_async", 32'(tick), 32'(0));
        model_reset();
        @(negedge clk);
        check_eq("rst_out_held", 32'(out), 32'(0));
        check_eq("rst_tick_held", 32'(tick), 32'(0));
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0] r_mode;
        logic       r_hold;
        rst  = 1'b1;
        mode = 2'd0;
        hold = 1'b0;
        model_reset();
        @(negedge clk);
        check_eq("reset_out", 32'(out), 32'(0));
        check_eq("reset_tick", 32'(tick), 32'(0));
        rst = 1'b0;

        // Binary count through a full wrap.
        for (int i = 0; i < 60; i++) cycle(2'd0, 1'b0);
        // Park on count 5 and freeze.
        for (int i = 0; i < 64 && (m_steps % CMOD) != 5; i++) cycle(2'd0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(2'd0, 1'b1);
        // Switch to the scanner exactly on a tick cycle.
        for (int i = 0; i < DIV && m_phase != DIV - 1; i++) cycle(2'd0, 1'b0);
        cycle(2'd2, 1'b0);
        for (int i = 0; i < 40; i++) cycle(2'd2, 1'b0);
        // Mode change while held still reinitialises.
        for (int i = 0; i < 5; i++) cycle(2'd2, 1'b1);
        for (int i = 0; i < 5; i++) cycle(2'd1, 1'b1);
        for (int i = 0; i < 60; i++) cycle(2'd1, 1'b0);
        for (int i = 0; i < 2 * DMAX * DIV + 20; i++) cycle(2'd3, 1'b0);
        async_reset();
        for (int i = 0; i < 30; i++) cycle(2'd0, 1'b0);

        r_mode = 2'd3;
        r_hold = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 29) == 0) r_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) r_hold = ~r_hold;
            if ($urandom_range(0, 299) == 0) begin
                async_reset();
            end else begin
                cycle(r_mode, r_hold);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_pattern.md
LED_PATTERN -- requirements
Module: led_pattern

Interface
REQ-001 Parameter WIDTH, default 8, number of driven output bits (>=1).
REQ-002 Parameter DIV_CNT, default 4194304, clocks per pattern step (>=1); 4194304 gives ~0.35 s at 12 MHz.
REQ-003 Parameter PWM_BITS, default 8, resolution of breathe-mode PWM counter and duty register.
REQ-004 CLK  input  1  single 12 MHz system clock, all logic on rising edge.
REQ-005 RST  input  1  asynchronous, active-high reset.
REQ-006 MODE  input  2  pattern select: 0 binary count, 1 Gray count, 2 bounce scanner, 3 PWM breathe.
REQ-007 HOLD  input  1  freeze pattern stepping while high.
REQ-008 OUT  output  WIDTH  registered pattern output driving LEDs/header pins.
REQ-009 TICK  output  1  one-cycle pulse on each pattern step.

Function
REQ-010 Prescaler SHALL count 0..DIV_CNT-1 and wrap; TICK SHALL be 1 for exactly the cycle the prescaler equals DIV_CNT-1; DIV_CNT=1 gives TICK every cycle.
REQ-011 While HOLD=1, prescaler, TICK (held 0) and step state SHALL freeze; PWM counter SHALL keep running.
REQ-012 Pattern state SHALL advance on the clock edge where TICK=1; OUT SHALL reflect updated state one edge later (1-cycle latency).
REQ-013 Mode 0: WIDTH-bit counter cnt increments per step, wraps all-ones -> 0; OUT = cnt.
REQ-014 Mode 1: same cnt; OUT = cnt XOR (cnt >> 1).
REQ-015 Mode 2: one-hot position pos, direction dir; sequence 0,1,...,WIDTH-1,WIDTH-2,...,0,1,...; end positions held one step only; WIDTH=1 keeps OUT=1.
REQ-016 Mode 3: free-running PWM_BITS counter pwm increments every clock; duty steps +1 per tick up to 2^PWM_BITS-1, then -1 per tick down to 0, then up again; all OUT bits = (pwm < duty).
REQ-017 Duty 0 SHALL give OUT all-zero continuously; maximum duty gives ones for 2^PWM_BITS-1 of every 2^PWM_BITS cycles.
REQ-018 MODE SHALL be registered internally (mode_q); on any edge where MODE != mode_q, cnt=0, pos=0, dir=up, duty=0, prescaler=0, TICK=0, and mode_q takes MODE; this takes priority over a coincident tick.
REQ-019 Mode change while HOLD=1 SHALL still reinitialise state; stepping remains frozen.
REQ-020 All arithmetic SHALL be modulo its register width; no state beyond cnt, pos, dir, duty, pwm, prescaler, mode_q, OUT.

Reset
REQ-021 RST=1 SHALL immediately force OUT=0, TICK=0, prescaler=0, cnt=0, pos=0, dir=up, duty=0, pwm=0, mode_q=0.
REQ-022 After RST deasserts, first TICK SHALL occur on the DIV_CNT-th rising edge; reset mid-pattern discards all progress.

Structure
REQ-023 Mode encodings (MODE_BIN=0, MODE_GRAY=1, MODE_SCAN=2, MODE_BREATHE=3) SHALL live in shared package led_pkg, reused by future LED blocks.
REQ-024 Prescaler SHALL be a sub-module tick_div (params DIV_CNT; ports CLK, RST, EN, CLR, TICK); remaining logic stays in led_pattern.

Verification
REQ-025 WIDTH=4, DIV_CNT=4, MODE=0: after reset, TICK every 4 cycles; OUT 0,1,2,...,15,0 with 1-cycle lag after each TICK.
REQ-026 WIDTH=4, DIV_CNT=1, MODE=1: OUT sequence 0000,0001,0011,0010,0110,...; exactly one bit changes per step, including 1000->0000 wrap.
REQ-027 WIDTH=4, DIV_CNT=2, MODE=2: OUT 0001,0010,0100,1000,0100,0010,0001,0010; no repeated end values.
REQ-028 PWM_BITS=3, DIV_CNT=8, MODE=3: duty 0 -> OUT 0 for 8 cycles; duty 7 -> ones 7 of 8 cycles; duty ramps 0..7..0.
REQ-029 MODE=0 at cnt=5, assert HOLD 20 cycles -> OUT stays 5, no TICK; switch MODE to 2 coincident with TICK -> pos=0, prescaler restarts, next TICK after DIV_CNT cycles.
REQ-030 Assert RST asynchronously between edges mid-count -> OUT and TICK 0 before next edge; release -> sequence restarts from 0.
